// File: rtl/mem_responder.sv
// mem_responder: wait-stated memory responder with a 256x8 internal RAM page,
// an optional write-protected upper region and a one-cycle completion strobe.
module mem_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [7:0]  RAM_PAGE    = 8'h80,
    parameter logic [7:0]  ROM_SPLIT   = 8'hC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        n_oe_mem,
    input  logic [7:0]  d_in,
    input  logic        wp,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        n_mem_rdy,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // With no wait states a capture goes straight to DONE on the same edge.
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [2:0] CNT_INIT = NO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic        capture;
    logic        enter_done;

    logic [15:0] cap_addr;
    logic        cap_rd_n;
    logic [7:0]  cap_din;
    logic        cap_wp;

    logic [15:0] eff_addr;
    logic        eff_rd_n;
    logic [7:0]  eff_din;
    logic        eff_wp;
    logic        eff_mapped;
    logic        eff_protect;
    logic        wr_ok;
    logic        ram_we;

    logic [7:0]  ram [256];

    // State and wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE/DONE always capture; WAIT counts down to zero.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        capture    = 1'b0;
        enter_done = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                capture = 1'b1;
                if (NO_WAIT) begin
                    state_nxt  = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt  = ST_DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Access selection: when capture and completion share an edge (no wait
    // states) the live inputs are the access, otherwise the captured copy.
    always_comb begin
        eff_addr    = capture ? addr     : cap_addr;
        eff_rd_n    = capture ? n_oe_mem : cap_rd_n;
        eff_din     = capture ? d_in     : cap_din;
        eff_wp      = capture ? wp       : cap_wp;
        eff_mapped  = (eff_addr[15:8] == RAM_PAGE);
        eff_protect = eff_wp && (eff_addr[7:0] >= ROM_SPLIT);
        wr_ok       = eff_mapped && !eff_protect;
        ram_we      = enter_done && eff_rd_n && wr_ok;
    end

    // Capture registers: latched on every capture edge, ignored during WAIT.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_addr <= addr;
            cap_rd_n <= n_oe_mem;
            cap_din  <= d_in;
            cap_wp   <= wp;
        end
    end

    // RAM write on the edge entering DONE; contents survive reset, and no
    // write can commit while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && ram_we) begin
            ram[eff_addr[7:0]] <= eff_din;
        end
    end

    // Registered read data, drive enable and error pulse for the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out   <= 8'h00;
            d_oe    <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            d_oe    <= 1'b0;
            bus_err <= 1'b0;
            if (enter_done) begin
                if (!eff_rd_n) begin
                    d_oe  <= 1'b1;
                    d_out <= eff_mapped ? ram[eff_addr[7:0]] : 8'hFF;
                end else begin
                    bus_err <= !wr_ok;
                end
            end
        end
    end

    assign n_mem_rdy = (state != ST_DONE);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized accesses against a transaction
// level memory model, on a two-wait-state and a zero-wait-state instance.
module tb_mem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] addr;
    logic        n_oe_mem;
    logic [7:0]  d_in;
    logic        wp;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        n_mem_rdy;
    logic        bus_err;

    logic [15:0] addr0;
    logic        n_oe_mem0;
    logic [7:0]  d_in0;
    logic        wp0;
    logic [7:0]  d_out0;
    logic        d_oe0;
    logic        n_mem_rdy0;
    logic        bus_err0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state for the two-wait-state instance.
    logic [7:0] mem   [256];
    bit         known [256];
    logic [7:0] exp_dout;
    bit         exp_dout_known;

    // Reference model for the zero-wait-state instance.
    logic [7:0] mem0 [256];

    mem_responder #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .addr(addr), .n_oe_mem(n_oe_mem), .d_in(d_in),
        .wp(wp), .d_out(d_out), .d_oe(d_oe), .n_mem_rdy(n_mem_rdy),
        .bus_err(bus_err)
    );

    mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .n_oe_mem(n_oe_mem0), .d_in(d_in0),
        .wp(wp0), .d_out(d_out0), .d_oe(d_oe0), .n_mem_rdy(n_mem_rdy0),
        .bus_err(bus_err0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access on the wait-stated instance: drive, capture,
    // scramble inputs during WAIT, then compare the DONE cycle to the model.
    task automatic access(input logic [15:0] a, input bit is_wr, input logic [7:0] v,
                          input bit prot);
        int   cycles;
        bit   done;
        bit   mapped;
        bit   ok;
        logic [7:0] idx;
        addr = a; n_oe_mem = is_wr; d_in = v; wp = prot;
        @(posedge clk);
        cycles = 0;
        done   = 0;
        while (!done && cycles < 12) begin
            @(negedge clk);
            cycles++;
            if (n_mem_rdy === 1'b0) begin
                done = 1;
            end else begin
                check("wait_d_oe", 16'(d_oe), 16'h0);
                check("wait_bus_err", 16'(bus_err), 16'h0);
                addr = 16'($urandom); n_oe_mem = 1'($urandom);
                d_in = 8'($urandom); wp = 1'($urandom);
            end
        end
        check("latency", 16'(cycles), 16'(WS + 1));
        idx    = a[7:0];
        mapped = (a[15:8] == 8'h80);
        if (is_wr) begin
            ok = mapped && !(prot && idx >= 8'hC0);
            check("wr_d_oe", 16'(d_oe), 16'h0);
            check("wr_bus_err", 16'(bus_err), 16'(!ok));
            if (exp_dout_known) check("wr_d_out_hold", 16'(d_out), 16'(exp_dout));
            if (ok) begin
                mem[idx]   = v;
                known[idx] = 1;
            end
        end else begin
            check("rd_d_oe", 16'(d_oe), 16'h1);
            check("rd_bus_err", 16'(bus_err), 16'h0);
            if (!mapped) begin
                exp_dout       = 8'hFF;
                exp_dout_known = 1;
            end else begin
                exp_dout       = mem[idx];
                exp_dout_known = known[idx];
            end
            if (exp_dout_known) check("rd_d_out", 16'(d_out), 16'(exp_dout));
        end
    endtask

    task automatic check_reset_outputs(input string who);
        check({who, "_n_mem_rdy"}, 16'(n_mem_rdy), 16'h1);
        check({who, "_d_oe"}, 16'(d_oe), 16'h0);
        check({who, "_bus_err"}, 16'(bus_err), 16'h0);
        check({who, "_d_out"}, 16'(d_out), 16'h00);
    endtask

    // One single-cycle access on the zero-wait instance.
    task automatic access0(input logic [15:0] a, input bit is_wr, input logic [7:0] v);
        addr0 = a; n_oe_mem0 = is_wr; d_in0 = v; wp0 = 1'b0;
        @(negedge clk);
        check("nw_n_mem_rdy", 16'(n_mem_rdy0), 16'h0);
        check("nw_d_oe", 16'(d_oe0), 16'(!is_wr));
        check("nw_bus_err", 16'(bus_err0), 16'h0);
        if (is_wr) mem0[a[7:0]] = v;
        else       check("nw_d_out", 16'(d_out0), 16'(mem0[a[7:0]]));
    endtask

    initial begin
        logic [7:0] vals [4];
        for (int i = 0; i < 256; i++) known[i] = 0;
        rst = 1'b1;
        addr = 16'h0; n_oe_mem = 1'b0; d_in = 8'h0; wp = 1'b0;
        addr0 = 16'h0; n_oe_mem0 = 1'b0; d_in0 = 8'h0; wp0 = 1'b0;
        exp_dout = 8'h00; exp_dout_known = 1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_nw_n_mem_rdy", 16'(n_mem_rdy0), 16'h1);
        check("reset_nw_d_out", 16'(d_out0), 16'h00);
        rst = 1'b0;

        // Basic write then read-back of a mapped location.
        access(16'h8010, 1, 8'h5A, 0);
        access(16'h8010, 0, 8'h00, 0);
        // Unmapped read and rejected unmapped write.
        access(16'h1234, 0, 8'h00, 0);
        access(16'h1234, 1, 8'h11, 0);
        // Protected region: rejected with wp=1, accepted with wp=0.
        access(16'h80C0, 1, 8'h33, 0);
        access(16'h80C0, 1, 8'hAA, 1);
        access(16'h80C0, 0, 8'h00, 0);
        access(16'h80C0, 1, 8'hAA, 0);
        access(16'h80C0, 0, 8'h00, 0);
        // Just below the protected split stays writable with wp=1.
        access(16'h80BF, 1, 8'h42, 1);
        access(16'h80BF, 0, 8'h00, 1);

        // Reset during WAIT of a write aborts it and leaves RAM alone.
        access(16'h8020, 1, 8'h3C, 0);
        access(16'h8020, 0, 8'h00, 0);
        addr = 16'h8020; n_oe_mem = 1'b1; d_in = 8'h77; wp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_wait");
        exp_dout = 8'h00; exp_dout_known = 1;
        @(negedge clk);
        rst = 1'b0;
        access(16'h8020, 0, 8'h00, 0);

        // Randomized accesses over a small address set so hits are frequent.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            a[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80;
            a[7:0]  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15))
                                                  : 8'($urandom_range(8'hB8, 8'hCF));
            access(a, 1'($urandom), 8'($urandom), 1'($urandom));
        end

        // Zero wait states: back-to-back single-cycle accesses.
        for (int i = 0; i < 4; i++) vals[i] = 8'($urandom);
        @(negedge clk);
        for (int i = 0; i < 3; i++) access0(16'h8000 + 16'(i), 1, vals[i]);
        for (int i = 0; i < 3; i++) access0(16'h8000 + 16'(i), 0, 8'h00);
        access0(16'h8003, 1, vals[3]);
        access0(16'h8003, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
